// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the FIR stream sequencer.
package fir_ctrl_pkg;

  // Sequencer phases: idle, coefficient load, delay-line flush, sample streaming.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam int DEF_NUM_TAPS = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_OUT_W    = 11;
  localparam int DEF_PIPE_LAT = 1;

  // Width of the tap counter; at least one bit so a single-tap build still has a register.
  function automatic int tap_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_valid_delay.sv
// PIPE_LAT-stage shift register that tracks which core cycles carry a real sample.
module fir_valid_delay #(
  parameter int PIPE_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [PIPE_LAT-1:0] sr;

  // Shift the sample marker one stage per cycle; clr empties the whole line at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else if (clr) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < PIPE_LAT; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[PIPE_LAT-1];

endmodule

// File: rtl/fir_stream_ctrl.sv
// Sequencer between the pins and the FIR core: loads coefficients, flushes the
// delay line with zeros, then streams samples and re-times the core output.
//
// Handshake: a byte moves from the pins when in_valid && in_ready are both high
// at a rising clk edge. in_ready is combinational from the state and cfg_req and
// never depends on in_valid; the source must hold in_data stable while in_valid
// is high and not yet accepted.
module fir_stream_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              cfg_req,
  output logic [DATA_W-1:0] fir_x,
  output logic              fir_tvalid,
  output logic              fir_set_coeffs,
  input  logic [OUT_W-1:0]  fir_y,
  output logic [OUT_W-1:0]  y_data,
  output logic              y_valid,
  output logic              busy,
  output logic              cfg_done,
  output state_t            state_dbg
);

  localparam int               TAP_W    = tap_cnt_w(NUM_TAPS);
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NUM_TAPS - 1);

  state_t            state, state_nxt;
  logic [TAP_W-1:0]  tap_cnt, tap_cnt_nxt;
  logic [DATA_W-1:0] fir_x_nxt;
  logic              tvalid_nxt, set_nxt, cfg_done_nxt;
  // run_sample marks a fir_tvalid cycle that carries a streamed sample (not a
  // coefficient or a flush zero); it is what feeds the valid delay line.
  logic              run_sample, run_sample_nxt;
  logic              dly_clr, dly_out;

  assign state_dbg = state;

  // State and tap counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      tap_cnt <= tap_cnt_nxt;
    end
  end

  // Next-state logic, handshake ready and next values of the core-facing registers.
  always_comb begin
    state_nxt      = state;
    tap_cnt_nxt    = tap_cnt;
    in_ready       = 1'b0;
    fir_x_nxt      = fir_x;
    tvalid_nxt     = 1'b0;
    set_nxt        = 1'b0;
    run_sample_nxt = 1'b0;
    cfg_done_nxt   = cfg_done;
    dly_clr        = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_req) begin
          state_nxt    = LOAD;
          cfg_done_nxt = 1'b0;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          fir_x_nxt  = in_data;
          tvalid_nxt = 1'b1;
          set_nxt    = 1'b1;
          if (tap_cnt == TAP_LAST) begin
            tap_cnt_nxt = '0;
            state_nxt   = FLUSH;
          end else begin
            tap_cnt_nxt = tap_cnt + TAP_W'(1);
          end
        end
      end
      FLUSH: begin
        fir_x_nxt  = '0;
        tvalid_nxt = 1'b1;
        if (tap_cnt == TAP_LAST) begin
          tap_cnt_nxt  = '0;
          state_nxt    = RUN;
          cfg_done_nxt = 1'b1;
        end else begin
          tap_cnt_nxt = tap_cnt + TAP_W'(1);
        end
      end
      RUN: begin
        // A reconfiguration request takes priority over a waiting sample.
        in_ready = !cfg_req;
        if (cfg_req) begin
          state_nxt    = LOAD;
          cfg_done_nxt = 1'b0;
          dly_clr      = 1'b1;
        end else if (in_valid) begin
          fir_x_nxt      = in_data;
          tvalid_nxt     = 1'b1;
          run_sample_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered drive of the core inputs and the status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fir_x          <= '0;
      fir_tvalid     <= 1'b0;
      fir_set_coeffs <= 1'b0;
      run_sample     <= 1'b0;
      cfg_done       <= 1'b0;
      busy           <= 1'b0;
    end else begin
      fir_x          <= fir_x_nxt;
      fir_tvalid     <= tvalid_nxt;
      fir_set_coeffs <= set_nxt;
      run_sample     <= run_sample_nxt;
      cfg_done       <= cfg_done_nxt;
      busy           <= (state_nxt == LOAD) || (state_nxt == FLUSH);
    end
  end

  fir_valid_delay #(
    .PIPE_LAT(PIPE_LAT)
  ) u_valid_delay (
    .clk  (clk),
    .reset(reset),
    .clr  (dly_clr),
    .din  (run_sample),
    .dout (dly_out)
  );

  // Capture the core output when the delayed marker says it belongs to a real sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_data  <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= dly_out;
      if (dly_out) begin
        y_data <= fir_y;
      end
    end
  end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Directed-plus-random bench for fir_stream_ctrl, run on a PIPE_LAT=1 and a
// PIPE_LAT=3 instance sharing the same pin stimulus.
module tb_fir_stream_ctrl;
  import fir_ctrl_pkg::*;

  localparam int NT = 4;
  localparam int DW = 8;
  localparam int OW = 11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          cfg_req = 1'b0;

  logic          rdy1, tv1, set1, yv1, busy1, cd1;
  logic [DW-1:0] x1;
  logic [OW-1:0] y1;
  state_t        st1;
  logic          rdy3, tv3, set3, yv3, busy3, cd3;
  logic [DW-1:0] x3;
  logic [OW-1:0] y3;
  state_t        st3;

  // Behavioural FIR cores: output is {3'b0, x} delayed by the core latency.
  logic [OW-1:0] fy1 = '0;
  logic [OW-1:0] fy3a = '0, fy3b = '0, fy3 = '0;
  always @(posedge clk) fy1 <= {3'b000, x1};
  always @(posedge clk) begin
    fy3a <= {3'b000, x3};
    fy3b <= fy3a;
    fy3  <= fy3b;
  end

  fir_stream_ctrl #(.NUM_TAPS(NT), .DATA_W(DW), .OUT_W(OW), .PIPE_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
    .cfg_req(cfg_req), .fir_x(x1), .fir_tvalid(tv1), .fir_set_coeffs(set1), .fir_y(fy1),
    .y_data(y1), .y_valid(yv1), .busy(busy1), .cfg_done(cd1), .state_dbg(st1)
  );

  fir_stream_ctrl #(.NUM_TAPS(NT), .DATA_W(DW), .OUT_W(OW), .PIPE_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy3),
    .cfg_req(cfg_req), .fir_x(x3), .fir_tvalid(tv3), .fir_set_coeffs(set3), .fir_y(fy3),
    .y_data(y3), .y_valid(yv3), .busy(busy3), .cfg_done(cd3), .state_dbg(st3)
  );

  // ---------------- reference model ----------------
  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  state_t        m_ph = IDLE;
  int            m_cnt = 0;
  logic [DW-1:0] m_x = '0;
  logic          m_tv = 1'b0, m_set = 1'b0, m_cd = 1'b0, m_busy = 1'b0;

  // Scoreboard: expected output words and the cycle each must appear in.
  logic [OW-1:0] exp1_q[$], exp3_q[$];
  int            due1_q[$], due3_q[$];
  logic [OW-1:0] m_y1 = '0, m_y3 = '0;

  logic [DW-1:0] coef[NT];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic check_ctrl();
    chk("fir_x1", 32'(x1), 32'(m_x));
    chk("fir_tvalid1", 32'(tv1), 32'(m_tv));
    chk("fir_set1", 32'(set1), 32'(m_set));
    chk("busy1", 32'(busy1), 32'(m_busy));
    chk("cfg_done1", 32'(cd1), 32'(m_cd));
    chk("state1", 32'(st1), 32'(m_ph));
    chk("fir_x3", 32'(x3), 32'(m_x));
    chk("fir_tvalid3", 32'(tv3), 32'(m_tv));
    chk("fir_set3", 32'(set3), 32'(m_set));
    chk("busy3", 32'(busy3), 32'(m_busy));
    chk("cfg_done3", 32'(cd3), 32'(m_cd));
    chk("state3", 32'(st3), 32'(m_ph));
  endtask

  // One clock cycle: check ready, let the edge happen, advance model, check outputs.
  task automatic tick();
    logic exp_rdy, xfer, v;
    #1;
    exp_rdy = (m_ph == LOAD) || (m_ph == RUN && !cfg_req);
    chk("in_ready1", 32'(rdy1), 32'(exp_rdy));
    chk("in_ready3", 32'(rdy3), 32'(exp_rdy));
    xfer = in_valid && exp_rdy;
    @(posedge clk);
    edge_n++;
    m_tv  = 1'b0;
    m_set = 1'b0;
    case (m_ph)
      IDLE: if (cfg_req) begin m_ph = LOAD; m_cnt = 0; m_cd = 1'b0; end
      LOAD: if (xfer) begin
        m_x = in_data; m_tv = 1'b1; m_set = 1'b1; m_cnt++;
        if (m_cnt == NT) begin m_ph = FLUSH; m_cnt = 0; end
      end
      FLUSH: begin
        m_x = '0; m_tv = 1'b1; m_cnt++;
        if (m_cnt == NT) begin m_ph = RUN; m_cnt = 0; m_cd = 1'b1; end
      end
      RUN: begin
        if (cfg_req) begin
          m_ph = LOAD; m_cnt = 0; m_cd = 1'b0;
          // Anything not yet at the output stage is lost with the pipeline.
          while (due1_q.size() > 0 && due1_q[$] >= edge_n + 2) begin
            void'(due1_q.pop_back()); void'(exp1_q.pop_back());
          end
          while (due3_q.size() > 0 && due3_q[$] >= edge_n + 2) begin
            void'(due3_q.pop_back()); void'(exp3_q.pop_back());
          end
        end else if (xfer) begin
          m_x = in_data; m_tv = 1'b1;
          exp1_q.push_back({3'b000, in_data}); due1_q.push_back(edge_n + 2 + 1);
          exp3_q.push_back({3'b000, in_data}); due3_q.push_back(edge_n + 2 + 3);
        end
      end
      default: ;
    endcase
    m_busy = (m_ph == LOAD) || (m_ph == FLUSH);
    #1;
    check_ctrl();
    v = (due1_q.size() > 0 && due1_q[0] == edge_n + 1);
    chk("y_valid1", 32'(yv1), 32'(v));
    if (v) begin m_y1 = exp1_q.pop_front(); void'(due1_q.pop_front()); end
    chk("y_data1", 32'(y1), 32'(m_y1));
    v = (due3_q.size() > 0 && due3_q[0] == edge_n + 1);
    chk("y_valid3", 32'(yv3), 32'(v));
    if (v) begin m_y3 = exp3_q.pop_front(); void'(due3_q.pop_front()); end
    chk("y_data3", 32'(y3), 32'(m_y3));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
    in_valid = v;
    in_data  = d;
    cfg_req  = r;
    tick();
  endtask

  // Send n coefficients from coef[]; cfg_req is toggled randomly since LOAD ignores it.
  task automatic load_seq(input int n, input logic gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) drive(1'b0, DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end
      drive(1'b1, coef[i], 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0);
  endtask

  // Asynchronous reset between edges: everything must clear without waiting for a clock.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    m_ph = IDLE; m_cnt = 0; m_x = '0; m_tv = 1'b0; m_set = 1'b0; m_cd = 1'b0; m_busy = 1'b0;
    exp1_q.delete(); due1_q.delete(); exp3_q.delete(); due3_q.delete();
    m_y1 = '0; m_y3 = '0;
    check_ctrl();
    chk("rst_in_ready1", 32'(rdy1), 32'(0));
    chk("rst_y_valid1", 32'(yv1), 32'(0));
    chk("rst_y_data1", 32'(y1), 32'(0));
    chk("rst_y_valid3", 32'(yv3), 32'(0));
    chk("rst_y_data3", 32'(y3), 32'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    do_reset();

    // IDLE ignores a waiting source.
    repeat (3) drive(1'b1, DW'($urandom_range(0, 255)), 1'b0);

    // Coefficient load with gaps, then flush with the source still pushing.
    drive(1'b0, '0, 1'b1);
    coef = '{8'h01, 8'h02, 8'h03, 8'h04};
    load_seq(NT, 1'b1);
    repeat (NT) drive(1'b1, DW'($urandom_range(0, 255)), 1'b0);

    // Back-to-back stream.
    drive(1'b1, 8'h10, 1'b0);
    drive(1'b1, 8'h20, 1'b0);
    drive(1'b1, 8'h30, 1'b0);
    idle(6);

    // Random stream with bubbles.
    repeat (40) drive(1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)), 1'b0);

    // Reconfiguration and a sample in the same cycle: reconfiguration wins.
    drive(1'b1, 8'h55, 1'b1);

    // Partial load interrupted by reset, then a complete fresh load.
    for (int i = 0; i < NT; i++) coef[i] = DW'($urandom_range(0, 255));
    load_seq(2, 1'b0);
    do_reset();
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < NT; i++) coef[i] = DW'($urandom_range(0, 255));
    load_seq(NT, 1'b1);
    repeat (NT) drive(1'b0, '0, 1'b0);
    repeat (30) drive(1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)), 1'b0);

    // cfg_req held high: LOAD, FLUSH, one RUN cycle, LOAD again.
    repeat (2 * (2 * NT + 1) + 3) drive(1'b1, DW'($urandom_range(0, 255)), 1'b1);

    // Release and let any load finish, then stream and drain.
    repeat (2 * NT + 8) drive(1'b1, DW'($urandom_range(0, 255)), 1'b0);
    idle(8);

    chk("sb_empty1", 32'(exp1_q.size()), 32'(0));
    chk("sb_empty3", 32'(exp3_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
